// File: rtl/simple_and.sv
// simple_and: bitwise AND gate with a registered observation path.
// f is the combinational AND of x and y. A small monitor registers f,
// flags per-bit rising/falling edges of the registered copy and counts
// the clock edges at which every bit of f is high (saturating counter).
module simple_and #(
  parameter int WIDTH     = 1,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic [WIDTH-1:0]     f,
  output logic [WIDTH-1:0]     f_q,
  output logic [WIDTH-1:0]     f_rise,
  output logic [WIDTH-1:0]     f_fall,
  output logic [CNT_WIDTH-1:0] hi_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]     f_s;
  logic                 all_high_s;
  logic [CNT_WIDTH-1:0] cnt_next_s;
  logic [WIDTH-1:0]     f_q_r;
  logic [WIDTH-1:0]     f_rise_r;
  logic [WIDTH-1:0]     f_fall_r;
  logic [CNT_WIDTH-1:0] hi_cnt_r;

  // Primary function: zero-latency, independent of clock and reset.
  assign f_s        = x & y;
  assign all_high_s = &f_s;

  // Saturating next count: advance only while all bits are high and not yet at the ceiling.
  always_comb begin
    cnt_next_s = hi_cnt_r;
    if (all_high_s && (hi_cnt_r != CNT_MAX)) begin
      cnt_next_s = hi_cnt_r + CNT_ONE;
    end else begin
      cnt_next_s = hi_cnt_r;
    end
  end

  // Monitor registers: reset wins; edge pulses compare the new sample against the previous f_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_q_r    <= {WIDTH{1'b0}};
      f_rise_r <= {WIDTH{1'b0}};
      f_fall_r <= {WIDTH{1'b0}};
      hi_cnt_r <= {CNT_WIDTH{1'b0}};
    end else begin
      f_q_r    <= f_s;
      f_rise_r <= f_s & ~f_q_r;
      f_fall_r <= ~f_s & f_q_r;
      hi_cnt_r <= cnt_next_s;
    end
  end

  assign f      = f_s;
  assign f_q    = f_q_r;
  assign f_rise = f_rise_r;
  assign f_fall = f_fall_r;
  assign hi_cnt = hi_cnt_r;

endmodule

// File: tb/tb_simple_and.sv
// Self-checking bench for simple_and: truth-table vectors, directed
// reset/edge/saturation sequences and randomized stimulus checked
// against a behavioural model, across three parameterisations.
module tb_simple_and;

  logic clk;
  logic rst_n;

  // Instance A: WIDTH=1, CNT_WIDTH=8
  logic       x1, y1, f1, fq1, fr1, ff1;
  logic [7:0] cnt1;
  // Instance B: WIDTH=1, CNT_WIDTH=2 (saturation)
  logic       xs, ys, fs, fqs, frs, ffs;
  logic [1:0] cnts;
  // Instance C: WIDTH=4, CNT_WIDTH=8
  logic [3:0] x4, y4, f4, fq4, fr4, ff4;
  logic [7:0] cnt4;

  simple_and #(.WIDTH(1), .CNT_WIDTH(8)) u_a (
    .clk(clk), .rst_n(rst_n), .x(x1), .y(y1), .f(f1),
    .f_q(fq1), .f_rise(fr1), .f_fall(ff1), .hi_cnt(cnt1));

  simple_and #(.WIDTH(1), .CNT_WIDTH(2)) u_s (
    .clk(clk), .rst_n(rst_n), .x(xs), .y(ys), .f(fs),
    .f_q(fqs), .f_rise(frs), .f_fall(ffs), .hi_cnt(cnts));

  simple_and #(.WIDTH(4), .CNT_WIDTH(8)) u_4 (
    .clk(clk), .rst_n(rst_n), .x(x4), .y(y4), .f(f4),
    .f_q(fq4), .f_rise(fr4), .f_fall(ff4), .hi_cnt(cnt4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Model state per instance
  logic [3:0] m1_fq, m1_r, m1_f;  int m1_c;
  logic [3:0] ms_fq, ms_r, ms_f;  int ms_c;
  logic [3:0] m4_fq, m4_r, m4_f;  int m4_c;

  typedef struct {
    logic x;
    logic y;
    logic f;
  } tt_vec_t;

  tt_vec_t tt[4];
  int sat_exp[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural rule for one clock edge: sampled f, its previous sample, and a saturating tally.
  task automatic mdl(input logic rn, input logic [3:0] fv, input int w, input int cmax,
                     inout logic [3:0] fq, inout logic [3:0] r, inout logic [3:0] fl,
                     inout int c);
    logic [3:0] mask;
    mask = (w == 4) ? 4'hF : 4'h1;
    if (!rn) begin
      fq = 4'h0; r = 4'h0; fl = 4'h0; c = 0;
    end else begin
      r  = fv & ~fq & mask;
      fl = ~fv & fq & mask;
      fq = fv & mask;
      if ((fv & mask) == mask) c = (c + 1 > cmax) ? cmax : c + 1;
    end
  endtask

  // Advance one clock edge, update all models, then compare every registered output.
  task automatic step();
    mdl(rst_n, {3'b0, x1 & y1}, 1, 255, m1_fq, m1_r, m1_f, m1_c);
    mdl(rst_n, {3'b0, xs & ys}, 1, 3,   ms_fq, ms_r, ms_f, ms_c);
    mdl(rst_n, x4 & y4,         4, 255, m4_fq, m4_r, m4_f, m4_c);
    @(posedge clk);
    #1;
    chk("a_f_q",    32'(fq1),  32'(m1_fq));
    chk("a_f_rise", 32'(fr1),  32'(m1_r));
    chk("a_f_fall", 32'(ff1),  32'(m1_f));
    chk("a_hi_cnt", 32'(cnt1), 32'(m1_c));
    chk("s_f_q",    32'(fqs),  32'(ms_fq));
    chk("s_f_rise", 32'(frs),  32'(ms_r));
    chk("s_f_fall", 32'(ffs),  32'(ms_f));
    chk("s_hi_cnt", 32'(cnts), 32'(ms_c));
    chk("w4_f_q",    32'(fq4),  32'(m4_fq));
    chk("w4_f_rise", 32'(fr4),  32'(m4_r));
    chk("w4_f_fall", 32'(ff4),  32'(m4_f));
    chk("w4_hi_cnt", 32'(cnt4), 32'(m4_c));
  endtask

  initial begin
    tt[0] = '{x: 1'b1, y: 1'b0, f: 1'b0};
    tt[1] = '{x: 1'b0, y: 1'b1, f: 1'b0};
    tt[2] = '{x: 1'b1, y: 1'b1, f: 1'b1};
    tt[3] = '{x: 1'b0, y: 1'b0, f: 1'b0};
    sat_exp = '{1, 2, 3, 3, 3, 3};

    m1_fq = 4'h0; m1_r = 4'h0; m1_f = 4'h0; m1_c = 0;
    ms_fq = 4'h0; ms_r = 4'h0; ms_f = 4'h0; ms_c = 0;
    m4_fq = 4'h0; m4_r = 4'h0; m4_f = 4'h0; m4_c = 0;
    rst_n = 1'b0;
    x1 = 1'b0; y1 = 1'b0; xs = 1'b0; ys = 1'b0; x4 = 4'h0; y4 = 4'h0;

    // 1. Truth table, combinational only
    for (int i = 0; i < 4; i++) begin
      x1 = tt[i].x; y1 = tt[i].y;
      #2;
      chk("tt_f", 32'(f1), 32'(tt[i].f));
      #3;
    end

    // 2. Reset held with x=y=1 over two edges; f stays valid
    x1 = 1'b1; y1 = 1'b1;
    step();
    step();
    chk("rst_f", 32'(f1), 32'd1);
    chk("rst_fq", 32'(fq1), 32'd0);
    chk("rst_cnt", 32'(cnt1), 32'd0);
    chk("rst_rise", 32'(fr1), 32'd0);

    // 3. Release reset, three high edges, then y=0
    rst_n = 1'b1;
    step();
    chk("e1_rise", 32'(fr1), 32'd1);
    chk("e1_cnt", 32'(cnt1), 32'd1);
    step();
    chk("e2_rise", 32'(fr1), 32'd0);
    chk("e2_cnt", 32'(cnt1), 32'd2);
    step();
    chk("e3_cnt", 32'(cnt1), 32'd3);
    y1 = 1'b0;
    #1;
    chk("e4_f", 32'(f1), 32'd0);
    step();
    chk("e4_fall", 32'(ff1), 32'd1);
    chk("e4_fq", 32'(fq1), 32'd0);
    chk("e4_cnt", 32'(cnt1), 32'd3);
    step();
    chk("e5_fall", 32'(ff1), 32'd0);

    // 4. Saturation on the 2-bit counter
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    xs = 1'b1; ys = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("sat_cnt", 32'(cnts), 32'(sat_exp[i]));
    end
    xs = 1'b0;

    // 5. Mid-run reset discards the count
    x1 = 1'b1; y1 = 1'b1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("mid_pre_cnt", 32'(cnt1), 32'd5);
    rst_n = 1'b0;
    step();
    chk("mid_cnt", 32'(cnt1), 32'd0);
    chk("mid_fq", 32'(fq1), 32'd0);
    rst_n = 1'b1;
    step();
    chk("mid_resume_cnt", 32'(cnt1), 32'd1);
    chk("mid_resume_rise", 32'(fr1), 32'd1);

    // 6. WIDTH=4 bitwise AND; partial match does not count
    x4 = 4'b1100; y4 = 4'b1010;
    #1;
    chk("w4_f", 32'(f4), 32'h8);
    step();
    chk("w4_nocnt", 32'(cnt4), 32'd0);
    chk("w4_rise", 32'(fr4), 32'h8);
    x4 = 4'hF; y4 = 4'hF;
    step();
    chk("w4_cnt", 32'(cnt4), 32'd1);
    chk("w4_rise2", 32'(fr4), 32'h7);

    // Randomized stimulus against the model
    for (int n = 0; n < 300; n++) begin
      rst_n = ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1;
      x1 = 1'($urandom); y1 = 1'($urandom);
      xs = 1'($urandom); ys = 1'($urandom);
      x4 = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      y4 = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      #1;
      chk("rnd_f1", 32'(f1), 32'(x1 & y1));
      chk("rnd_f4", 32'(f4), 32'(x4 & y4));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
